// File: rtl/mux_select_arbiter.sv
// Two-requester round-robin arbiter driving the select line of the registered 2:1 operand mux,
// with a hold limit under contention and a valid/owner tag aligned to the mux output register.
module mux_select_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic select,
  output logic out_valid,
  output logic out_owner
);

  localparam int unsigned CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] hold_cnt_r;
  logic [CW-1:0] hold_cnt_s;
  logic          last_r;
  logic          last_s;
  logic          select_r;
  logic          select_s;
  logic          gnt0_r;
  logic          gnt1_r;
  logic          out_valid_r;
  logic          out_owner_r;
  logic          enter_s;

  // Next-state selection: round-robin on ties, handoff on release, preemption at the hold limit.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req0 && req1) begin
          state_s = last_r ? GRANT0 : GRANT1;
        end else if (req0) begin
          state_s = GRANT0;
        end else if (req1) begin
          state_s = GRANT1;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT0: begin
        if (!req0) begin
          state_s = req1 ? GRANT1 : IDLE;
        end else if (req1 && (hold_cnt_r == HOLD_LIM)) begin
          state_s = GRANT1;
        end else begin
          state_s = GRANT0;
        end
      end
      GRANT1: begin
        if (!req1) begin
          state_s = req0 ? GRANT0 : IDLE;
        end else if (req0 && (hold_cnt_r == HOLD_LIM)) begin
          state_s = GRANT0;
        end else begin
          state_s = GRANT1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Bookkeeping for the next owner: hold counter, last owner and mux select.
  always_comb begin
    enter_s    = (state_s != state_r) && (state_s != IDLE);
    hold_cnt_s = hold_cnt_r;
    last_s     = last_r;
    select_s   = select_r;
    if (enter_s) begin
      hold_cnt_s = {CW{1'b0}};
      last_s     = (state_s == GRANT1);
      select_s   = (state_s == GRANT1);
    end else if ((state_s != IDLE) && (hold_cnt_r != HOLD_LIM)) begin
      hold_cnt_s = hold_cnt_r + CW'(1);
    end else begin
      hold_cnt_s = hold_cnt_r;
    end
  end

  // State and output registers; out_valid/out_owner trail the grant by the mux register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      hold_cnt_r  <= {CW{1'b0}};
      last_r      <= 1'b1;
      select_r    <= 1'b0;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_owner_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      hold_cnt_r  <= hold_cnt_s;
      last_r      <= last_s;
      select_r    <= select_s;
      gnt0_r      <= (state_s == GRANT0);
      gnt1_r      <= (state_s == GRANT1);
      out_valid_r <= gnt0_r | gnt1_r;
      out_owner_r <= select_r;
    end
  end

  assign gnt0      = gnt0_r;
  assign gnt1      = gnt1_r;
  assign select    = select_r;
  assign out_valid = out_valid_r;
  assign out_owner = out_owner_r;

endmodule
